imem_fetch_ctrl: RTL and testbench

Instruction-fetch controller for the byte-wide instruction memory (64 K × 8, big-endian 16-bit instructions at even addresses). It owns the program counter and assembles each instruction from two consecutive byte reads. Fetched instructions are buffered in a small prefetch FIFO and handed to decode with a valid/ready handshake. It also arbitrates the single memory port between fetch, PC redirects and an optional program-loader write port.

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_fetch_ctrl_fifo.sv | 54 +++++
 rtl/imem_fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared widths, FSM states and prefetch entry type for imem_fetch_ctrl.
// The LOAD state exists only when IMEM_LOADER_EN is defined.
package imem_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RD_HI,
        RD_LO
`ifdef IMEM_LOADER_EN
        , LOAD
`endif
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// fetch_fifo: shift-register prefetch FIFO; entry 0 is the registered head.
// Flush clears the count at the next edge and wins over push and pop.
module fetch_fifo
    import imem_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          valid,
    output logic [CW-1:0] count
);

    fetch_entry_t  ent [DEPTH];
    logic [CW-1:0] cnt;
    logic [AW-1:0] wr_idx;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt < CW'(DEPTH)) || do_pop);

    always_comb begin
        wr_idx = cnt[AW-1:0];
        if (do_pop) wr_idx = AW'(cnt - CW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) ent[i] <= ent[i+1];
            end
            if (do_push) ent[wr_idx] <= din;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head  = ent[0];
    assign valid = (cnt != '0);
    assign count = cnt;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC owner and two-byte instruction assembler for the byte-wide imem.
// Define IMEM_LOADER_EN to add the program-loader write port and LOAD state.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
`ifdef IMEM_LOADER_EN
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [BYTE_W-1:0] ld_data,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] EVEN = ~ADDR_W'(1);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pend_pc;
    logic [BYTE_W-1:0] hi_q;
    logic              lo_pend;
    logic [CW-1:0]     fcount;
    logic              credit;
    logic              issue_hi;
    logic              at_bnd;
    logic              pop;
    fetch_entry_t      push_e;
    fetch_entry_t      head_e;

`ifdef IMEM_LOADER_EN
    logic [ADDR_W-1:0] ld_addr_q;
    logic [BYTE_W-1:0] ld_data_q;
`endif

    // lo_pend is the second in-flight instruction while the low byte returns
    assign credit   = (int'(fcount) + int'(lo_pend)) < FIFO_DEPTH;
    assign issue_hi = (state == RD_HI) && credit;
    assign at_bnd   = (state == IDLE) || (state == RD_LO)
                   || ((state == RD_HI) && !credit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC & EVEN;
            pend_pc <= '0;
            hi_q    <= '0;
            lo_pend <= 1'b0;
`ifdef IMEM_LOADER_EN
            ld_addr_q <= '0;
            ld_data_q <= '0;
`endif
        end else begin
            lo_pend <= 1'b0;
            if (redirect_valid) begin
                pc    <= redirect_pc & EVEN;
                state <= RD_HI;
            end else begin
                if (state == RD_LO) begin
                    hi_q    <= mem_rdata;
                    pend_pc <= pc;
                    pc      <= pc + ADDR_W'(2);
                    lo_pend <= 1'b1;
                end
                if (at_bnd) begin
`ifdef IMEM_LOADER_EN
                    if (ld_valid) begin
                        state     <= LOAD;
                        ld_addr_q <= ld_addr;
                        ld_data_q <= ld_data;
                    end else begin
                        state <= RD_HI;
                    end
`else
                    state <= RD_HI;
`endif
                end else if (state == RD_HI) begin
                    state <= RD_LO;
                end else begin
                    state <= RD_HI;
                end
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
`ifdef IMEM_LOADER_EN
        ld_ready  = 1'b0;
`endif
        unique case (1'b1)
            issue_hi: begin
                mem_en   = 1'b1;
                mem_addr = pc;
            end
            (state == RD_LO): begin
                mem_en   = 1'b1;
                mem_addr = pc | ADDR_W'(1);
            end
`ifdef IMEM_LOADER_EN
            (state == LOAD): begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ld_addr_q;
                mem_wdata = ld_data_q;
                ld_ready  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign push_e.pc    = pend_pc;
    assign push_e.instr = {hi_q, mem_rdata};
    assign pop          = instr_valid && instr_ready;

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (lo_pend),
        .din   (push_e),
        .pop   (pop),
        .head  (head_e),
        .valid (instr_valid),
        .count (fcount)
    );

    assign instr    = head_e.instr;
    assign instr_pc = head_e.pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: byte-memory model plus scoreboard of expected {pc, instr}.
// Loader scenario is built only when IMEM_LOADER_EN is defined.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
`ifdef IMEM_LOADER_EN
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [15:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
`endif
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
`ifdef IMEM_LOADER_EN
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
`endif
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    logic [7:0]  mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] sbq [$];
    logic [15:0] rdq [$];
    logic        sb_on = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          ld_cnt = 0;
    logic        prev_hi = 1'b0;
    logic        ld_after_hi = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_at(input logic [15:0] a);
        logic [15:0] b;
        b = a + 16'd1;
        return {a, ref_mem[a], ref_mem[b]};
    endfunction

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(sbq.size()), 32'd0);
        sb_on       = 1'b0;
        instr_ready = 1'b0;
        sbq.delete();
    endtask

    task automatic apply_reset();
        sb_on          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        rst_n          = 1'b0;
        tick();
        tick();
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        else mem_rdata <= 8'($urandom);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_en && !mem_we) rdq.push_back(mem_addr);
`ifdef IMEM_LOADER_EN
            if (ld_ready) begin
                ld_cnt++;
                ld_after_hi = prev_hi;
            end
`endif
            prev_hi = mem_en && !mem_we && !mem_addr[0];
        end
    end

    // Scoreboard: every accepted head must match the next expected entry
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && sb_on && instr_valid && instr_ready) begin
            e = (sbq.size() != 0) ? sbq.pop_front() : 32'hxxxx_xxxx;
            check("sb_instr", {instr_pc, instr}, e);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t_rd, t_v1, t_v2, tv, r, mark;
        logic found;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h12;
        mem[1] = 8'h34;
        mem[2] = 8'h56;
        mem[3] = 8'h78;
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
        #2;

        // Reset values, then streaming fetch with ready high
        apply_reset();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);
        check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 32'd0);
`ifdef IMEM_LOADER_EN
        check("rst_ldrdy", 32'(ld_ready), 32'd0);
`endif
        for (int a = 0; a < 8; a += 2) sbq.push_back(exp_at(16'(a)));
        t_rd = -1; t_v1 = -1; t_v2 = -1;
        rst_n = 1'b1;
        instr_ready = 1'b1;
        sb_on = 1'b1;
        for (int i = 0; i < 30 && t_v2 < 0; i++) begin
            @(negedge clk);
            if (t_rd < 0 && mem_en && !mem_we) t_rd = cyc;
            if (instr_valid) begin
                if (t_v1 < 0) t_v1 = cyc;
                else if (t_v2 < 0) t_v2 = cyc;
            end
        end
        check("s1_latency", 32'(t_v1 - t_rd), 32'd3);
        check("s1_rate", 32'(t_v2 - t_v1), 32'd2);
        drain("s1_drain", 40);

        // Back-pressure: two instructions buffered, then fetch stalls
        apply_reset();
        mark = rdq.size();
        rst_n = 1'b1;
        repeat (12) tick();
        check("s2_reads", 32'(rdq.size() - mark), 32'd4);
        check("s2_stall", 32'(mem_en), 32'd0);
        check("s2_head", {instr_pc, instr}, exp_at(16'h0000));
        for (int a = 0; a < 8; a += 2) sbq.push_back(exp_at(16'(a)));
        mark = rdq.size();
        sb_on = 1'b1;
        instr_ready = 1'b1;
        drain("s2_drain", 40);
        check("s2_resume", 32'(rdq[mark]), 32'h0004);

        // Redirect during RD_LO squashes the in-flight byte
        apply_reset();
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (mem_en && !mem_we && mem_addr == 16'h0001) found = 1'b1;
        end
        check("s3_find", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0101;
        r = cyc;
        tick();
        redirect_valid = 1'b0;
        mark = rdq.size();
        check("s3_gap", 32'(instr_valid), 32'd0);
        sbq.push_back(exp_at(16'h0100));
        sbq.push_back(exp_at(16'h0102));
        sb_on = 1'b1;
        instr_ready = 1'b1;
        tv = -1;
        for (int i = 0; i < 10 && tv < 0; i++) begin
            @(negedge clk);
            if (instr_valid) tv = cyc;
        end
        check("s3_latency", 32'(tv - r), 32'd4);
        drain("s3_drain", 40);
        check("s3_addr", 32'(rdq[mark]), 32'h0100);

        // 16-bit PC wrap from FFFE
        apply_reset();
        rst_n = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        mark = rdq.size();
        sbq.push_back(exp_at(16'hFFFE));
        sbq.push_back(exp_at(16'h0000));
        sb_on = 1'b1;
        instr_ready = 1'b1;
        drain("s4_drain", 40);
        check("s4_rd0", 32'(rdq[mark]), 32'hFFFE);
        check("s4_rd1", 32'(rdq[mark+1]), 32'hFFFF);
        check("s4_rd2", 32'(rdq[mark+2]), 32'h0000);
        check("s4_rd3", 32'(rdq[mark+3]), 32'h0001);

`ifdef IMEM_LOADER_EN
        // Loader write during fetch, read back through a redirect
        apply_reset();
        rst_n = 1'b1;
        instr_ready = 1'b1;
        repeat (3) tick();
        ld_valid = 1'b1;
        ld_addr = 16'h0010;
        ld_data = 8'hA5;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (ld_ready) found = 1'b1;
        end
        check("s5_grant", 32'(found), 32'd1);
        check("s5_wr", {mem_en, mem_we, mem_addr, mem_wdata},
              {1'b1, 1'b1, 16'h0010, 8'hA5, 6'd0} >> 6);
        tick();
        ld_valid = 1'b0;
        ref_mem[16'h0010] = 8'hA5;
        repeat (6) tick();
        check("s5_once", 32'(ld_cnt), 32'd1);
        check("s5_bnd", 32'(ld_after_hi), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect_valid = 1'b0;
        sbq.push_back(exp_at(16'h0010));
        sb_on = 1'b1;
        drain("s5_drain", 40);
`endif

        // Reset asserted mid-instruction
        apply_reset();
        rst_n = 1'b1;
        instr_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (mem_en && !mem_we && mem_addr == 16'h0005) found = 1'b1;
        end
        check("s6_find", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 32'd0);
        check("s6_head", {15'd0, instr_valid, instr}, 32'd0);
        check("s6_pc", 32'(instr_pc), 32'd0);
        tick();
        tick();
        mark = rdq.size();
        sbq.push_back(exp_at(16'h0000));
        sbq.push_back(exp_at(16'h0002));
        sb_on = 1'b1;
        rst_n = 1'b1;
        check("s6_empty", 32'(instr_valid), 32'd0);
        drain("s6_drain", 40);
        check("s6_restart", 32'(rdq[mark]), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
